// File: rtl/counter_pkg.sv
// Shared encodings for the timer subsystem: count-source selects and count modes.
package counter_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE    = 2'b00,
    EDGE_FALL    = 2'b01,
    EDGE_BOTH    = 2'b10,
    EDGE_CASCADE = 2'b11
  } edge_sel_e;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_CTC    = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser for an asynchronous input plus history flop; emits registered
// one-cycle rise/fall pulses once the pipeline holds only post-reset samples.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [SYNC_STAGES:0]   r_arm;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // r_arm keeps a level held through reset from looking like an edge on release
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_arm  <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= w_sync_out;
      r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      o_rise <= r_arm[SYNC_STAGES] &  w_sync_out & ~r_hist;
      o_fall <= r_arm[SYNC_STAGES] & ~w_sync_out &  r_hist;
    end
  end

endmodule

// File: rtl/edge_timer_counter.sv
// Edge/cascade driven timer with normal and clear-on-compare-A modes, load and
// clear, and registered one-cycle overflow/match event pulses.
module edge_timer_counter
  import counter_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CounterClock,
  input  logic                 CounterReset_n,
  input  logic                 TcIn,
  input  logic                 CascadeTick,
  input  logic [1:0]           CounterEdge,
  input  logic                 CountEnable,
  input  logic                 CtcMode,
  input  logic                 counterClear,
  input  logic                 LoadEn,
  input  logic [BIT_WIDTH-1:0] LoadValue,
  input  logic [BIT_WIDTH-1:0] CompareA,
  input  logic [BIT_WIDTH-1:0] CompareB,
  output logic [BIT_WIDTH-1:0] Count,
  output logic                 Overflow,
  output logic                 MatchA,
  output logic                 MatchB
);

  localparam logic [BIT_WIDTH-1:0] ALL_ONES = {BIT_WIDTH{1'b1}};

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_src;
  logic                 w_ev;
  logic                 w_hit_a;
  logic [BIT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic                 r_match_a;
  logic                 r_match_b;

  function automatic logic [BIT_WIDTH-1:0] f_next_count(
    input logic [BIT_WIDTH-1:0] cur,
    input logic                 ctc,
    input logic                 hit_a
  );
    if (ctc == MODE_CTC && hit_a) return '0;
    return cur + BIT_WIDTH'(1);
  endfunction

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk   (CounterClock),
    .i_rst_n (CounterReset_n),
    .i_async (TcIn),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_src = 1'b0;
    case (edge_sel_e'(CounterEdge))
      EDGE_RISE:    w_src = w_rise;
      EDGE_FALL:    w_src = w_fall;
      EDGE_BOTH:    w_src = w_rise | w_fall;
      EDGE_CASCADE: w_src = CascadeTick;
      default:      w_src = 1'b0;
    endcase
  end

  assign w_ev    = w_src & CountEnable;
  assign w_hit_a = (r_count == CompareA);

  // Clear and load win over the event and swallow it together with its pulses
  always_ff @(posedge CounterClock) begin
    if (!CounterReset_n) begin
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_match_a <= 1'b0;
      r_match_b <= 1'b0;
    end else begin
      r_ovf     <= 1'b0;
      r_match_a <= 1'b0;
      r_match_b <= 1'b0;
      if (counterClear) begin
        r_count <= '0;
      end else if (LoadEn) begin
        r_count <= LoadValue;
      end else if (w_ev) begin
        r_ovf     <= (r_count == ALL_ONES);
        r_match_a <= w_hit_a;
        r_match_b <= (r_count == CompareB);
        r_count   <= f_next_count(r_count, CtcMode, w_hit_a);
      end
    end
  end

  assign Count    = r_count;
  assign Overflow = r_ovf;
  assign MatchA   = r_match_a;
  assign MatchB   = r_match_b;

endmodule

// File: tb/tb_edge_timer_counter.sv
// Directed bench for edge_timer_counter: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_edge_timer_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tc_in;
  logic       casc;
  logic [1:0] edge_sel;
  logic       cen;
  logic       ctc;
  logic       clr;
  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic [7:0] count;
  logic       ovf;
  logic       ma;
  logic       mb;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       ov;
    logic       ma;
    logic       mb;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;
  bit   done    = 0;

  edge_timer_counter #(.BIT_WIDTH(8), .SYNC_STAGES(2)) dut (
    .CounterClock   (clk),
    .CounterReset_n (rst_n),
    .TcIn           (tc_in),
    .CascadeTick    (casc),
    .CounterEdge    (edge_sel),
    .CountEnable    (cen),
    .CtcMode        (ctc),
    .counterClear   (clr),
    .LoadEn         (ld),
    .LoadValue      (ld_val),
    .CompareA       (cmp_a),
    .CompareB       (cmp_b),
    .Count          (count),
    .Overflow       (ovf),
    .MatchA         (ma),
    .MatchB         (mb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expect outputs as seen after the posedge that is n edges from now
  task automatic expect_at(input int n, input int c, input logic o, input logic a,
                           input logic b, input string nm);
    exp_t e;
    int   idx;
    e.cyc = cyc + n; e.cnt = 8'(c); e.ov = o; e.ma = a; e.mb = b; e.name = nm;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > e.cyc) begin idx = i; break; end
    end
    q.insert(idx, e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tc_set(input logic v, input logic counts);
    tc_in = v;
    if (counts) begin
      expect_at(3, exp_cnt, 0, 0, 0, "edge_before");
      exp_cnt++;
      expect_at(4, exp_cnt, 0, 0, 0, "edge_inc");
    end
    step(); step();
  endtask

  task automatic tick(input int c, input logic o, input logic a, input logic b,
                      input string nm);
    casc = 1'b1;
    expect_at(1, c, o, a, b, nm);
    step();
  endtask

  task automatic idle(input int c, input string nm);
    casc = 1'b0;
    expect_at(1, c, 0, 0, 0, nm);
    step();
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1'b1; ld_val = v;
    expect_at(1, v, 0, 0, 0, "load");
    step();
    ld = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d not checked by cycle %0d", e.name, e.cyc, cyc);
      end else if (count !== e.cnt || ovf !== e.ov || ma !== e.ma || mb !== e.mb) begin
        bad++;
        $display("FAIL %s @cyc %0d: got cnt=%02h ov=%b ma=%b mb=%b, want cnt=%02h ov=%b ma=%b mb=%b",
                 e.name, cyc, count, ovf, ma, mb, e.cnt, e.ov, e.ma, e.mb);
      end
    end
  end

  initial begin
    rst_n = 1'b0; tc_in = 1'b1; casc = 1'b0; edge_sel = 2'b00; cen = 1'b1;
    ctc = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = 8'h00; cmp_a = 8'h80; cmp_b = 8'h80;

    // Reset with TcIn high, then release: no rising event
    for (int i = 0; i < 3; i++) begin step(); expect_at(0, 0, 0, 0, 0, "reset"); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin expect_at(1, 0, 0, 0, 0, "release"); step(); end
    tc_in = 1'b0;
    for (int i = 0; i < 6; i++) begin expect_at(1, 0, 0, 0, 0, "fall_in_rise"); step(); end

    // Rising, falling, both-edge counting
    for (int i = 0; i < 5; i++) begin tc_set(1'b1, 1'b1); tc_set(1'b0, 1'b0); end
    step(); step(); step(); step();
    edge_sel = 2'b01;
    for (int i = 0; i < 5; i++) begin tc_set(1'b1, 1'b0); tc_set(1'b0, 1'b1); end
    step(); step(); step(); step();
    edge_sel = 2'b10;
    for (int i = 0; i < 5; i++) begin tc_set(1'b1, 1'b1); tc_set(1'b0, 1'b1); end
    step(); step(); step(); step();
    expect_at(0, 20, 0, 0, 0, "edge_total");

    // Normal wrap via cascade ticks
    edge_sel = 2'b11;
    load(8'hFE);
    tick(8'hFF, 0, 0, 0, "wrap_ff");
    tick(8'h00, 1, 0, 0, "wrap_00");
    idle(8'h00, "wrap_idle");

    // CTC mode
    ctc = 1'b1; cmp_a = 8'h03; cmp_b = 8'h01;
    tick(1, 0, 0, 0, "ctc1"); tick(2, 0, 0, 1, "ctc2");
    tick(3, 0, 0, 0, "ctc3"); tick(0, 0, 1, 0, "ctc4");
    tick(1, 0, 0, 0, "ctc5"); tick(2, 0, 0, 1, "ctc6");
    tick(3, 0, 0, 0, "ctc7"); tick(0, 0, 1, 0, "ctc8");
    idle(0, "ctc_idle");
    load(8'hFF);
    tick(0, 1, 0, 0, "ctc_ovf");
    idle(0, "ctc_ovf_idle");

    // Priority: load and clear drop the event and its pulses
    ctc = 1'b0; cmp_a = 8'h00; cmp_b = 8'h00;
    casc = 1'b1; ld = 1'b1; ld_val = 8'h40;
    expect_at(1, 8'h40, 0, 0, 0, "load_vs_tick");
    step();
    cmp_a = 8'h40; cmp_b = 8'h40; clr = 1'b1;
    expect_at(1, 0, 0, 0, 0, "clr_vs_load_tick");
    step();
    clr = 1'b0; ld = 1'b0; cmp_a = 8'h80; cmp_b = 8'h80;
    idle(0, "prio_idle");

    // Enable gating, then reset mid-count
    load(8'h10);
    cen = 1'b0;
    for (int i = 0; i < 4; i++) tick(8'h10, 0, 0, 0, "disabled");
    cen = 1'b1;
    tick(8'h11, 0, 0, 0, "enabled1");
    tick(8'h12, 0, 0, 0, "enabled2");
    rst_n = 1'b0;
    tick(0, 0, 0, 0, "mid_reset");
    rst_n = 1'b1;
    tick(1, 0, 0, 0, "after_reset");
    idle(1, "final_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
